patch_rotation_ctrl: RTL and testbench
======================================

PATCH_ROTATION_CTRL -- requirements
Module: patch_rotation_ctrl

Interface
REQ-001: Parameter PATCH_SIZE, default 16, words per patch; the node address runs 0..PATCH_SIZE-1.
REQ-002: Parameter DATA_W, default 18, signed sample width.
REQ-003: clk  input  1  single clock; all state updates on posedge clk.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: start  input  1  one-cycle request to run num_steps time steps; sampled only in IDLE.
REQ-006: num_steps  input  8  step count, latched when start is accepted.
REQ-007: busy  output  1  high whenever state is not IDLE.
REQ-008: done  output  1  one-cycle pulse when the run completes.
REQ-009: mem_addr  output  4  node address presented to the 3-patch sample memory.
REQ-010: mem_patch  output  2  patch index (0..2) presented to the memory.
REQ-011: mem_we  output  1  memory write enable.
REQ-012: mem_wdata  output  DATA_W  memory write data.
REQ-013: mem_rdata  input  DATA_W  memory read data, valid exactly 1 cycle after address.
REQ-014: node_valid / node_ready  output / input  1 / 1  offer handshake to the compute engine.
REQ-015: u_cur, u_prev  output  DATA_W each  node samples offered with node_valid.
REQ-016: node_idx  output  4  node address of the current offer.
REQ-017: res_valid  input  1  compute result strobe; res_data  input  DATA_W  new sample u_next.

Function
REQ-018: The block SHALL keep three distinct patch roles cur, prev and next, each a 2-bit index in the range 0..2.
REQ-019: States SHALL be IDLE, RD_CUR, RD_PREV, OFFER, WAIT_RES, WR and ROTATE.
REQ-020: IDLE: start=1 latches num_steps and clears node addr and step_cnt; if num_steps=0, done pulses next cycle and the state stays IDLE, otherwise next state is RD_CUR.
REQ-021: RD_CUR drives mem_patch=cur, mem_addr=addr and mem_we=0 for one cycle.
REQ-022: RD_PREV drives mem_patch=prev with the same addr and captures mem_rdata into u_cur.
REQ-023: On entry to OFFER the block SHALL capture mem_rdata into u_prev.
REQ-024: In OFFER, node_valid=1 and node_idx=addr; u_cur, u_prev and node_idx SHALL stay stable until node_ready=1, at which point the state moves to WAIT_RES.
REQ-025: WAIT_RES holds until res_valid=1, captures res_data and moves to WR; res_valid SHALL be ignored in every other state.
REQ-026: WR drives mem_we=1, mem_patch=next, mem_addr=addr and mem_wdata=captured result for exactly one cycle.
REQ-027: After WR, if addr<PATCH_SIZE-1 then addr increments and the state goes to RD_CUR; otherwise the state goes to ROTATE.
REQ-028: ROTATE SHALL update the roles simultaneously as prev<=cur, cur<=next, next<=prev, increment step_cnt, and clear addr to 0.
REQ-029: After ROTATE, if step_cnt equals the latched num_steps, done pulses and the state goes to IDLE; otherwise the state goes to RD_CUR.
REQ-030: Role indices SHALL persist across runs; a new start continues from the current rotation.
REQ-031: start while busy SHALL be ignored, with no relatch and no effect.
REQ-032: mem_we SHALL be 1 only in WR; in all other states mem_addr and mem_patch hold their last values.
REQ-033: Each node SHALL take 5 cycles plus handshake waits, so a minimum step is 5*PATCH_SIZE+1 cycles.

Reset
REQ-034: rst_n=0 SHALL immediately force IDLE, cur=0, prev=1, next=2, addr=0, step_cnt=0, and set busy, done, node_valid, mem_we, mem_addr, mem_patch, mem_wdata, u_cur, u_prev and node_idx to 0.
REQ-035: Reset asserted mid-run SHALL abort without completing a pending write; done is not pulsed.

Verification
REQ-036: Reset, then start with num_steps=1 and a compute model returning u_cur+1 with node_ready and res_valid tied high -> 16 writes to patch 2 at addrs 0..15, then roles cur=2, prev=0, next=1; done after 81 cycles.
REQ-037: num_steps=3 -> role sequence (cur,prev,next) = (0,1,2) -> (2,0,1) -> (1,2,0) -> (0,1,2); exactly one done pulse.
REQ-038: node_ready held low 7 cycles at node 5 -> node_valid stays high with stable u_cur, u_prev and node_idx=5; no memory access occurs.
REQ-039: start with num_steps=0 -> done one cycle later, busy never high, no mem_we.
REQ-040: rst_n pulsed low during WAIT_RES at node 9 -> no WR cycle, all outputs 0 at once, roles back to (0,1,2); a second start mid-run is ignored.

Source files
------------

// File: rtl/patch_rotation_ctrl.sv
// patch_rotation_ctrl
// Sequences one explicit time-stepping sweep over a three-patch sample memory.
// For every node it reads the current and previous samples, offers them to
// the compute engine, waits for the new sample and writes it into the "next"
// patch. After the last node the three patch roles rotate, so no data is ever
// copied between patches.
//
// Memory timing: mem_addr/mem_patch are driven combinationally from the state
// during RD_CUR, RD_PREV and WR and otherwise hold their last value. The memory
// returns read data one cycle after the address. Consequently the cur sample
// arrives during RD_PREV and the prev sample arrives during the first OFFER
// cycle. In that first cycle u_prev is forwarded straight from mem_rdata and
// registered at the same time, which keeps it stable for the rest of the offer.
module patch_rotation_ctrl #(
    parameter int PATCH_SIZE = 16,
    parameter int DATA_W     = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        num_steps,
    output logic              busy,
    output logic              done,
    output logic [3:0]        mem_addr,
    output logic [1:0]        mem_patch,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              node_valid,
    input  logic              node_ready,
    output logic [DATA_W-1:0] u_cur,
    output logic [DATA_W-1:0] u_prev,
    output logic [3:0]        node_idx,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data
);

    localparam logic [3:0] LAST_ADDR = 4'(PATCH_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_CUR,
        S_RD_PREV,
        S_OFFER,
        S_WAIT_RES,
        S_WR,
        S_ROTATE
    } state_t;

    state_t state, state_nxt;

    // Patch roles; they survive between runs so a new start continues the rotation.
    logic [1:0] role_cur, role_prev, role_next;

    logic [3:0] addr;
    logic [7:0] step_cnt;
    logic [7:0] step_inc;
    logic [7:0] steps_q;

    logic signed [DATA_W-1:0] u_cur_q;
    logic signed [DATA_W-1:0] u_prev_q;
    logic signed [DATA_W-1:0] res_q;
    logic                     offer_first;

    logic [3:0] addr_hold;
    logic [1:0] patch_hold;
    logic       done_q;

    assign step_inc = step_cnt + 8'd1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && (num_steps != 8'd0)) begin
                    state_nxt = S_RD_CUR;
                end
            end
            S_RD_CUR:  state_nxt = S_RD_PREV;
            S_RD_PREV: state_nxt = S_OFFER;
            S_OFFER: begin
                if (node_ready) begin
                    state_nxt = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                if (res_valid) begin
                    state_nxt = S_WR;
                end
            end
            S_WR: begin
                if (addr == LAST_ADDR) begin
                    state_nxt = S_ROTATE;
                end else begin
                    state_nxt = S_RD_CUR;
                end
            end
            S_ROTATE: begin
                if (step_inc == steps_q) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_RD_CUR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state; memory address holds between accesses
    always_comb begin
        busy       = (state != S_IDLE);
        node_valid = (state == S_OFFER);
        mem_we     = (state == S_WR);
        mem_addr   = addr_hold;
        mem_patch  = patch_hold;
        case (state)
            S_RD_CUR: begin
                mem_addr  = addr;
                mem_patch = role_cur;
            end
            S_RD_PREV: begin
                mem_addr  = addr;
                mem_patch = role_prev;
            end
            S_WR: begin
                mem_addr  = addr;
                mem_patch = role_next;
            end
            default: ;
        endcase
        u_prev = (state == S_OFFER && offer_first) ? mem_rdata : u_prev_q;
    end

    assign u_cur     = u_cur_q;
    assign mem_wdata = res_q;
    assign node_idx  = addr;
    assign done      = done_q;

    // Remember the last presented memory address so it holds outside access states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_hold  <= '0;
            patch_hold <= '0;
        end else begin
            addr_hold  <= mem_addr;
            patch_hold <= mem_patch;
        end
    end

    // Node address and step bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            step_cnt <= '0;
            steps_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr     <= '0;
                        step_cnt <= '0;
                        steps_q  <= num_steps;
                    end
                end
                S_WR: begin
                    if (addr != LAST_ADDR) begin
                        addr <= addr + 4'd1;
                    end
                end
                S_ROTATE: begin
                    addr     <= '0;
                    step_cnt <= step_inc;
                end
                default: ;
            endcase
        end
    end

    // Rotate the three patch roles at the end of every step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            role_cur  <= 2'd0;
            role_prev <= 2'd1;
            role_next <= 2'd2;
        end else if (state == S_ROTATE) begin
            role_prev <= role_cur;
            role_cur  <= role_next;
            role_next <= role_prev;
        end
    end

    // Capture samples from memory and the result from the compute engine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_cur_q     <= '0;
            u_prev_q    <= '0;
            res_q       <= '0;
            offer_first <= 1'b0;
        end else begin
            offer_first <= (state == S_RD_PREV);
            if (state == S_RD_PREV) begin
                u_cur_q <= mem_rdata;
            end
            if (state == S_OFFER && offer_first) begin
                u_prev_q <= mem_rdata;
            end
            if (state == S_WAIT_RES && res_valid) begin
                res_q <= res_data;
            end
        end
    end

    // Completion pulse: immediate for a zero-step request, else after the final rotate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= ((state == S_IDLE) && start && (num_steps == 8'd0)) ||
                      ((state == S_ROTATE) && (step_inc == steps_q));
        end
    end

endmodule

// File: tb/tb_patch_rotation_ctrl.sv
// Testbench for patch_rotation_ctrl: three-patch memory model, a compute
// engine stand-in with optional random handshake delays, and a reference
// model that evaluates whole time steps over arrays.
module tb_patch_rotation_ctrl;

    localparam int PS = 16;
    localparam int DW = 18;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [7:0]    num_steps;
    logic          busy;
    logic          done;
    logic [3:0]    mem_addr;
    logic [1:0]    mem_patch;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          node_valid;
    logic          node_ready;
    logic [DW-1:0] u_cur;
    logic [DW-1:0] u_prev;
    logic [3:0]    node_idx;
    logic          res_valid;
    logic [DW-1:0] res_data;

    patch_rotation_ctrl #(.PATCH_SIZE(PS), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_steps(num_steps),
        .busy(busy), .done(done), .mem_addr(mem_addr), .mem_patch(mem_patch),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .node_valid(node_valid), .node_ready(node_ready), .u_cur(u_cur),
        .u_prev(u_prev), .node_idx(node_idx), .res_valid(res_valid),
        .res_data(res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- memory model ----------------
    logic [DW-1:0] mem      [0:2][0:PS-1];
    logic [DW-1:0] init_img [0:2][0:PS-1];
    logic          load;

    always @(posedge clk) begin
        if (load) mem <= init_img;
        else if (mem_we && mem_patch != 2'd3) mem[mem_patch][mem_addr] <= mem_wdata;
        mem_rdata <= (mem_patch != 2'd3) ? mem[mem_patch][mem_addr] : '0;
    end

    // ---------------- compute engine ----------------
    int            fmode;
    logic          pending;
    logic [DW-1:0] eng_res;
    logic          rand_mode, stall_hold, res_tie, res_block;
    logic          rdy_rand, rv_rand;

    function automatic logic [DW-1:0] f_new(input logic [DW-1:0] c, input logic [DW-1:0] p,
                                            input int m);
        if (m == 0) return DW'(c + 1);
        return DW'(c + p);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (node_valid && node_ready) begin
            eng_res <= f_new(u_cur, u_prev, fmode);
            pending <= 1'b1;
        end else if (res_valid) begin
            pending <= 1'b0;
        end
    end

    always @(negedge clk) begin
        rdy_rand = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        rv_rand  = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    assign node_ready = rdy_rand & ~stall_hold;
    assign res_valid  = ~res_block & (res_tie | (pending & rv_rand));
    assign res_data   = eng_res;

    // ---------------- monitors ----------------
    typedef struct { int p; int a; logic [DW-1:0] d; } wr_t;
    typedef struct { int idx; logic [DW-1:0] c; logic [DW-1:0] p; } off_t;
    wr_t  wr_q[$];
    off_t off_q[$];
    int   done_cnt = 0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (mem_we) wr_q.push_back('{p: int'(mem_patch), a: int'(mem_addr), d: mem_wdata});
            if (node_valid && node_ready)
                off_q.push_back('{idx: int'(node_idx), c: u_cur, p: u_prev});
            if (done) done_cnt++;
        end
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] mdl [0:2][0:PS-1];
    int   mc, mp, mn;
    wr_t  exp_wr[$];
    off_t exp_off[$];

    // Whole time steps: next[a] = f(cur[a], prev[a]) for every node, then the
    // patch that was prev becomes the new next, cur becomes prev, next becomes cur.
    // abort_at >= 0: the first step stops after offering that node (no write).
    task automatic model_run(input int n, input int abort_at);
        int t;
        logic [DW-1:0] v;
        for (int s = 0; s < n; s++) begin
            for (int a = 0; a < PS; a++) begin
                exp_off.push_back('{idx: a, c: mdl[mc][a], p: mdl[mp][a]});
                if (abort_at >= 0 && a == abort_at) return;
                v = f_new(mdl[mc][a], mdl[mp][a], fmode);
                exp_wr.push_back('{p: mn, a: a, d: v});
                mdl[mn][a] = v;
            end
            t  = mp;
            mp = mc;
            mc = mn;
            mn = t;
        end
    endtask

    function automatic int wr_diff(input int from);
        int bad = 0;
        if (wr_q.size() - from != exp_wr.size()) return -1;
        for (int i = 0; i < exp_wr.size(); i++)
            if (wr_q[from+i].p != exp_wr[i].p || wr_q[from+i].a != exp_wr[i].a ||
                wr_q[from+i].d !== exp_wr[i].d) bad++;
        return bad;
    endfunction

    function automatic int off_diff(input int from);
        int bad = 0;
        if (off_q.size() - from != exp_off.size()) return -1;
        for (int i = 0; i < exp_off.size(); i++)
            if (off_q[from+i].idx != exp_off[i].idx || off_q[from+i].c !== exp_off[i].c ||
                off_q[from+i].p !== exp_off[i].p) bad++;
        return bad;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic init_mem();
        for (int p = 0; p < 3; p++)
            for (int a = 0; a < PS; a++) begin
                init_img[p][a] = DW'($urandom);
                mdl[p][a]      = init_img[p][a];
            end
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mc = 0; mp = 1; mn = 2;
    endtask

    task automatic run(input int n, output int cyc, output int dn);
        int d0 = done_cnt;
        num_steps = 8'(n);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            if (done) break;
        end
        @(posedge clk); #1;
        dn = done_cnt - d0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, node_valid, mem_we} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: busy/done/valid/we got %b, want 0000", {busy, done, node_valid, mem_we});
        end
        n_cmp++;
        if ({mem_addr, mem_patch, node_idx} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_addr: addr/patch/idx got %h, want 0", {mem_addr, mem_patch, node_idx});
        end
        n_cmp++;
        if ({mem_wdata, u_cur, u_prev} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: wdata=%h u_cur=%h u_prev=%h, want 0", mem_wdata, u_cur, u_prev);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        mc = 0; mp = 1; mn = 2;
    endtask

    task automatic test_single_step();
        int cyc, dn, ws, os, d;
        init_mem();
        fmode = 0; rand_mode = 1'b0; res_tie = 1'b1;
        exp_wr.delete(); exp_off.delete();
        ws = wr_q.size(); os = off_q.size();
        model_run(1, -1);
        run(1, cyc, dn);
        n_cmp++;
        if (cyc !== 81) begin n_fail++; $display("FAIL single_cycles: got %0d, want 81", cyc); end
        n_cmp++;
        if (dn !== 1) begin n_fail++; $display("FAIL single_done: got %0d pulses, want 1", dn); end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b, want 0", busy); end
        d = wr_diff(ws);
        n_cmp++;
        if (d !== 0) begin n_fail++; $display("FAIL single_writes: %0d bad (got %0d writes, want %0d)", d, wr_q.size()-ws, exp_wr.size()); end
        d = off_diff(os);
        n_cmp++;
        if (d !== 0) begin n_fail++; $display("FAIL single_offers: %0d bad (got %0d offers, want %0d)", d, off_q.size()-os, exp_off.size()); end
        // Roles now (2,0,1): a further step must write patch 1 from cur patch 2.
        exp_wr.delete(); exp_off.delete();
        ws = wr_q.size(); os = off_q.size();
        model_run(1, -1);
        run(1, cyc, dn);
        n_cmp++;
        if (wr_q.size() <= ws || wr_q[ws].p != 1) begin
            n_fail++;
            $display("FAIL persist_patch: got %0d, want 1", (wr_q.size() > ws) ? wr_q[ws].p : -1);
        end
        d = wr_diff(ws) + off_diff(os);
        n_cmp++;
        if (d !== 0) begin n_fail++; $display("FAIL persist_stream: %0d bad entries, want 0", d); end
    endtask

    task automatic test_three_steps();
        int cyc, dn, ws, os, d;
        pulse_reset();
        fmode = 1; rand_mode = 1'b1; res_tie = 1'b0;
        exp_wr.delete(); exp_off.delete();
        ws = wr_q.size(); os = off_q.size();
        model_run(3, -1);
        run(3, cyc, dn);
        n_cmp++;
        if (dn !== 1) begin n_fail++; $display("FAIL three_done: got %0d pulses, want 1 (cycles %0d)", dn, cyc); end
        n_cmp++;
        if (wr_q.size() < ws + 48 || wr_q[ws].p != 2 || wr_q[ws+16].p != 1 || wr_q[ws+32].p != 0) begin
            n_fail++;
            $display("FAIL three_roles: got %0d writes, want 48 to patches 2,1,0", wr_q.size()-ws);
        end
        d = wr_diff(ws);
        n_cmp++;
        if (d !== 0) begin n_fail++; $display("FAIL three_writes: %0d bad, want 0", d); end
        d = off_diff(os);
        n_cmp++;
        if (d !== 0) begin n_fail++; $display("FAIL three_offers: %0d bad, want 0", d); end
        rand_mode = 1'b0; res_tie = 1'b1;
    endtask

    task automatic test_stall();
        int cyc, k, bad, ws, os, d, d0;
        logic armed;
        logic [DW-1:0] sc, sp;
        logic [3:0] sa;
        logic [1:0] spt;
        fmode = 0;
        exp_wr.delete(); exp_off.delete();
        ws = wr_q.size(); os = off_q.size(); d0 = done_cnt;
        model_run(1, -1);
        num_steps = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; k = 0; bad = 0; armed = 1'b0;
        while (cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            if (done) break;
            if (k > 0) begin
                if (!node_valid || node_idx !== 4'd5 || u_cur !== sc || u_prev !== sp ||
                    mem_we || mem_addr !== sa || mem_patch !== spt) bad++;
                k--;
                if (k == 0) stall_hold = 1'b0;
            end else if (!armed && node_valid && node_idx == 4'd5) begin
                armed = 1'b1; stall_hold = 1'b1; k = 7;
                sc = u_cur; sp = u_prev; sa = mem_addr; spt = mem_patch;
            end
        end
        stall_hold = 1'b0;
        n_cmp++;
        if (!armed || bad !== 0) begin n_fail++; $display("FAIL stall_stable: armed=%b unstable cycles=%0d, want 1/0", armed, bad); end
        n_cmp++;
        if (sc !== exp_off[5].c || sp !== exp_off[5].p) begin
            n_fail++;
            $display("FAIL stall_values: got %h/%h, want %h/%h", sc, sp, exp_off[5].c, exp_off[5].p);
        end
        n_cmp++;
        if (cyc !== 88) begin n_fail++; $display("FAIL stall_cycles: got %0d, want 88", cyc); end
        @(posedge clk); #1;
        d = wr_diff(ws) + off_diff(os);
        n_cmp++;
        if (d !== 0 || done_cnt - d0 != 1) begin n_fail++; $display("FAIL stall_stream: %0d bad, %0d done, want 0/1", d, done_cnt-d0); end
    endtask

    task automatic test_zero_steps();
        int ws = wr_q.size();
        int bad = 0;
        num_steps = 8'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_done: done=%b busy=%b, want 1/0", done, busy); end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad !== 0 || wr_q.size() != ws) begin
            n_fail++;
            $display("FAIL zero_quiet: bad=%0d writes=%0d, want 0/0", bad, wr_q.size()-ws);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, cyc2, dn, ws, os, d, d0;
        fmode = 1;
        exp_wr.delete(); exp_off.delete();
        ws = wr_q.size(); os = off_q.size(); d0 = done_cnt;
        model_run(1, -1);
        num_steps = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
            start = (cyc == 20);
            num_steps = (cyc == 20) ? 8'd5 : 8'd1;
            if (done) break;
        end
        start = 1'b0;
        n_cmp++;
        if (cyc !== 81) begin n_fail++; $display("FAIL b2b_ignore_start: got %0d cycles, want 81", cyc); end
        model_run(1, -1);
        run(1, cyc2, dn);
        n_cmp++;
        if (cyc2 !== 81 || done_cnt - d0 != 2) begin
            n_fail++;
            $display("FAIL b2b_second: cycles=%0d done=%0d, want 81/2", cyc2, done_cnt-d0);
        end
        d = wr_diff(ws) + off_diff(os);
        n_cmp++;
        if (d !== 0) begin n_fail++; $display("FAIL b2b_stream: %0d bad, want 0", d); end
    endtask

    task automatic test_reset_mid_run();
        int cyc, dn, ws, os, d, d0;
        logic hit;
        fmode = 0;
        pulse_reset();
        exp_wr.delete(); exp_off.delete();
        ws = wr_q.size(); os = off_q.size(); d0 = done_cnt;
        model_run(2, 9);
        num_steps = 8'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; hit = 1'b0;
        while (cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
            start = node_valid && node_idx == 4'd3;
            if (node_valid && node_idx == 4'd9) begin
                res_tie = 1'b0; res_block = 1'b1; hit = 1'b1;
                break;
            end
        end
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (!hit || {busy, done, node_valid, mem_we, mem_addr, mem_patch, node_idx} !== '0 ||
            {mem_wdata, u_cur, u_prev} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: hit=%b busy=%b we=%b addr=%h patch=%h wdata=%h, want all 0",
                     hit, busy, mem_we, mem_addr, mem_patch, mem_wdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; res_block = 1'b0; res_tie = 1'b1;
        mc = 0; mp = 1; mn = 2;
        repeat (3) @(posedge clk);
        #1;
        d = wr_diff(ws) + off_diff(os);
        n_cmp++;
        if (d !== 0 || done_cnt != d0) begin
            n_fail++;
            $display("FAIL abort_stream: %0d bad (writes %0d), done=%0d, want 0 bad, 9 writes, 0 done", d, wr_q.size()-ws, done_cnt-d0);
        end
        exp_wr.delete(); exp_off.delete();
        ws = wr_q.size(); os = off_q.size();
        model_run(1, -1);
        run(1, cyc, dn);
        n_cmp++;
        if (wr_q.size() <= ws || wr_q[ws].p != 2 || wr_diff(ws) + off_diff(os) != 0) begin
            n_fail++;
            $display("FAIL abort_roles: first write patch %0d, want 2 with matching stream",
                     (wr_q.size() > ws) ? wr_q[ws].p : -1);
        end
    endtask

    task automatic test_random();
        int cyc, dn, ws, os, d, n;
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 3);
            fmode = $urandom_range(0, 1);
            rand_mode = 1'b1; res_tie = 1'b0;
            exp_wr.delete(); exp_off.delete();
            ws = wr_q.size(); os = off_q.size();
            model_run(n, -1);
            run(n, cyc, dn);
            d = wr_diff(ws) + off_diff(os);
            n_cmp++;
            if (d !== 0 || dn !== 1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL random_run%0d: steps=%0d bad=%0d done=%0d busy=%b, want 0/1/0", r, n, d, dn, busy);
            end
        end
        rand_mode = 1'b0; res_tie = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_steps = 8'd0; load = 1'b0;
        fmode = 0; rand_mode = 1'b0; stall_hold = 1'b0; res_tie = 1'b1; res_block = 1'b0;
        mc = 0; mp = 1; mn = 2;
        test_reset();
        test_single_step();
        test_three_steps();
        test_stall();
        test_zero_steps();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
